// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on its input and output.
// Single-cycle ops load the result register on accept. The result is then held
// until the consumer takes it. Each result carries zero/carry/overflow/negative
// flags and an exception flag for undefined opcodes.
// Optional feature macro: ALU_SEQ_MUL_EN. When it is defined, opcode 0110 is a
// signed shift-add multiply. It takes DATA_WIDTH cycles in an EXEC state.
module alu_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_operandA,
  input  logic [DATA_WIDTH-1:0] i_operandB,
  input  logic [3:0]            i_opcode,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_zero,
  output logic                  o_carry,
  output logic                  o_overflow,
  output logic                  o_negative,
  output logic                  o_exception
);

  localparam int W       = DATA_WIDTH;
  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_SLL = 4'b0000;
  localparam logic [3:0] OP_SRL = 4'b0010;
  localparam logic [3:0] OP_SRA = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_AND = 4'b1100;
  localparam logic [3:0] OP_OR  = 4'b1101;
  localparam logic [3:0] OP_XOR = 4'b1110;
  localparam logic [3:0] OP_NOR = 4'b1111;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0110;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_HOLD} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD} state_t;
`endif

  state_t state_q, state_d;

  logic [W-1:0] result_q, result_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic         ovf_q, ovf_d;
  logic         neg_q, neg_d;
  logic         exc_q, exc_d;

  logic   accept;
  logic   load_alu;
  state_t accept_target;

  // Handshake: IDLE always accepts. HOLD accepts only when the result is
  // being consumed in the same cycle.
  assign o_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && i_ready);
  assign o_valid = (state_q == ST_HOLD);
  assign accept  = i_valid && o_ready;

`ifdef ALU_SEQ_MUL_EN
  logic op_is_mul;
  assign op_is_mul     = (i_opcode == OP_MUL);
  assign load_alu      = accept && !op_is_mul;
  assign accept_target = op_is_mul ? ST_EXEC : ST_HOLD;
`else
  assign load_alu      = accept;
  assign accept_target = ST_HOLD;
`endif

  // Single-cycle datapath, evaluated on the live operands at accept.
  // Each shift is done on a vector one bit wider than the operand. The extra
  // bit receives the last bit shifted out, and is 0 for a shift of 0.
  logic [W:0]         add_sum;
  logic [W-1:0]       sub_diff;
  logic [SHAMT_W-1:0] shamt;
  logic [W:0]         sll_ext;
  logic [W:0]         srl_ext;
  logic [W:0]         sra_ext;

  assign add_sum  = {1'b0, i_operandA} + {1'b0, i_operandB};
  assign sub_diff = i_operandA - i_operandB;
  assign shamt    = i_operandB[SHAMT_W-1:0];
  assign sll_ext  = {1'b0, i_operandA} << shamt;
  assign srl_ext  = {i_operandA, 1'b0} >> shamt;
  assign sra_ext  = $signed({i_operandA, 1'b0}) >>> shamt;

  logic [W-1:0] alu_res;
  logic         alu_c, alu_v, alu_x;

  // Opcode decode for all single-cycle operations and their carry/overflow.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_x   = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        alu_res = add_sum[W-1:0];
        alu_c   = add_sum[W];
        alu_v   = (i_operandA[W-1] == i_operandB[W-1]) &&
                  (add_sum[W-1] != i_operandA[W-1]);
      end
      OP_SUB: begin
        alu_res = sub_diff;
        alu_c   = (i_operandA < i_operandB);
        alu_v   = (i_operandA[W-1] != i_operandB[W-1]) &&
                  (sub_diff[W-1] != i_operandA[W-1]);
      end
      OP_AND: alu_res = i_operandA & i_operandB;
      OP_OR:  alu_res = i_operandA | i_operandB;
      OP_XOR: alu_res = i_operandA ^ i_operandB;
      OP_NOR: alu_res = ~(i_operandA | i_operandB);
      OP_SLL: begin
        alu_res = sll_ext[W-1:0];
        alu_c   = sll_ext[W];
      end
      OP_SRL: begin
        alu_res = srl_ext[W:1];
        alu_c   = srl_ext[0];
      end
      OP_SRA: begin
        alu_res = sra_ext[W:1];
        alu_c   = sra_ext[0];
      end
      default: alu_x = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // Iterative signed multiply. The multiplicand is sign-extended to 2W bits
  // and shifted left each cycle. The multiplier is consumed LSB first. The
  // final (sign) bit's partial product is subtracted, as it carries negative
  // weight in two's complement.
  logic [2*W-1:0]     mcand_q, mcand_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [W-1:0]       mplier_q, mplier_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]     pp;
  logic [2*W-1:0]     prod_step;
  logic [W:0]         prod_top;
  logic               mul_last;

  assign mul_last  = (state_q == ST_EXEC) && (cnt_q == '0);
  assign pp        = mplier_q[0] ? mcand_q : '0;
  assign prod_step = (cnt_q == '0) ? (acc_q - pp) : (acc_q + pp);
  assign prod_top  = prod_step[2*W-1:W-1];

  // Multiplier iteration registers: loaded at accept, stepped once per EXEC cycle.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (accept && op_is_mul) begin
      mcand_d  = {{W{i_operandA[W-1]}}, i_operandA};
      acc_d    = '0;
      mplier_d = i_operandB;
      cnt_d    = SHAMT_W'(W - 1);
    end else if (state_q == ST_EXEC) begin
      acc_d    = prod_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - SHAMT_W'(1);
    end
  end

  // Multiplier state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  // Result/flag next-state: load on single-cycle accept or on the final multiply step.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    exc_d    = exc_q;
    if (load_alu) begin
      result_d = alu_res;
      zero_d   = !alu_x && (alu_res == '0);
      carry_d  = alu_c;
      ovf_d    = alu_v;
      neg_d    = alu_res[W-1];
      exc_d    = alu_x;
    end
`ifdef ALU_SEQ_MUL_EN
    if (mul_last) begin
      result_d = prod_step[W-1:0];
      zero_d   = (prod_step[W-1:0] == '0);
      carry_d  = 1'b0;
      // The product fits in W bits only if its top W+1 bits are all equal.
      ovf_d    = !((&prod_top) || !(|prod_top));
      neg_d    = prod_step[W-1];
      exc_d    = 1'b0;
    end
`endif
  end

  // Control FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = accept_target;
`ifdef ALU_SEQ_MUL_EN
      ST_EXEC: if (cnt_q == '0) state_d = ST_HOLD;
`endif
      ST_HOLD: if (i_ready) state_d = accept ? accept_target : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      exc_q    <= exc_d;
    end
  end

  assign o_result    = result_q;
  assign o_zero      = zero_q;
  assign o_carry     = carry_q;
  assign o_overflow  = ovf_q;
  assign o_negative  = neg_q;
  assign o_exception = exc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (DATA_WIDTH = 8).
// A monitor pushes the model's expected result when an op is accepted.
// It pops and compares when a result is consumed. Directed checks cover latency,
// back-pressure and reset. Multiply checks run only when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;

  localparam int DW = 8;

  localparam logic [3:0] T_SLL = 4'b0000;
  localparam logic [3:0] T_SRL = 4'b0010;
  localparam logic [3:0] T_SRA = 4'b0011;
  localparam logic [3:0] T_MUL = 4'b0110;
  localparam logic [3:0] T_UND = 4'b0111;
  localparam logic [3:0] T_ADD = 4'b1000;
  localparam logic [3:0] T_SUB = 4'b1010;
  localparam logic [3:0] T_AND = 4'b1100;
  localparam logic [3:0] T_OR  = 4'b1101;
  localparam logic [3:0] T_XOR = 4'b1110;
  localparam logic [3:0] T_NOR = 4'b1111;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_operandA;
  logic [DW-1:0] i_operandB;
  logic [3:0]    i_opcode;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_result;
  logic          o_zero, o_carry, o_overflow, o_negative, o_exception;

  int n_tests = 0;
  int n_fail  = 0;
  logic [12:0] sb_q[$];

  alu_seq #(.DATA_WIDTH(DW)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_operandA  (i_operandA),
    .i_operandB  (i_operandB),
    .i_opcode    (i_opcode),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_zero      (o_zero),
    .o_carry     (o_carry),
    .o_overflow  (o_overflow),
    .o_negative  (o_negative),
    .o_exception (o_exception)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [12:0] outs();
    return {o_result, o_zero, o_carry, o_overflow, o_negative, o_exception};
  endfunction

  // Reference model: returns {result, zero, carry, overflow, negative, exception}.
  function automatic logic [12:0] model(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    int ua, ub, sa, sb, t, sh;
    logic [7:0] r;
    logic c, v, x;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[2:0]);
    r = 8'h00; c = 1'b0; v = 1'b0; x = 1'b0;
    case (op)
      T_ADD: begin
        t = ua + ub; r = t[7:0]; c = t[8];
        t = sa + sb; v = (t > 127) || (t < -128);
      end
      T_SUB: begin
        t = ua - ub; r = t[7:0]; c = (ua < ub);
        t = sa - sb; v = (t > 127) || (t < -128);
      end
      T_AND: r = a & b;
      T_OR:  r = a | b;
      T_XOR: r = a ^ b;
      T_NOR: r = ~(a | b);
      T_SLL: begin
        r = a;
        for (int i = 0; i < sh; i++) begin c = r[7]; r = {r[6:0], 1'b0}; end
      end
      T_SRL: begin
        r = a;
        for (int i = 0; i < sh; i++) begin c = r[0]; r = {1'b0, r[7:1]}; end
      end
      T_SRA: begin
        r = a;
        for (int i = 0; i < sh; i++) begin c = r[0]; r = {r[7], r[7:1]}; end
      end
`ifdef ALU_SEQ_MUL_EN
      T_MUL: begin
        t = sa * sb; r = t[7:0];
        v = (t > 127) || (t < -128);
      end
`endif
      default: x = 1'b1;
    endcase
    return {r, (!x && r == 8'h00), c, v, r[7], x};
  endfunction

  // Scoreboard monitor, sampled on the falling edge: consume first, then accept.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
        else check("sb_result", 32'(outs()), 32'(sb_q.pop_front()));
      end
      if (i_valid && o_ready) sb_q.push_back(model(i_opcode, i_operandA, i_operandB));
    end
  end

  // Present one op and wait (bounded) for it to be accepted; returns just after the edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic took;
    took = 1'b0;
    i_opcode = op; i_operandA = a; i_operandB = b; i_valid = 1'b1;
    for (int k = 0; k < 100 && !took; k++) begin
      @(negedge i_clock);
      took = o_ready;
      @(posedge i_clock);
      #1;
    end
    if (!took) check("send_timeout", 32'd0, 32'd1);
    i_valid = 1'b0;
  endtask

  // Single-cycle op: its result must be valid right after the accept edge.
  task automatic send_lat(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b);
    send(op, a, b);
    @(negedge i_clock);
    check(tag, 32'(o_valid), 32'd1);
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  logic [3:0] b2b_op [4];
  logic [7:0] b2b_a  [4];
  logic [7:0] b2b_b  [4];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_operandA = '0; i_operandB = '0; i_opcode = '0;
    b2b_op = '{T_ADD, T_NOR, T_SLL, T_SUB};
    b2b_a  = '{8'h12, 8'h0F, 8'h41, 8'h80};
    b2b_b  = '{8'h34, 8'hF0, 8'h03, 8'h01};

    // Reset state.
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_outs", 32'(outs()), 32'd0);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    @(negedge i_clock);
    check("rst_ready", 32'(o_ready), 32'd1);
    @(posedge i_clock); #1;

    // Arithmetic with flags.
    send_lat("add_lat", T_ADD, 8'h7F, 8'h01);
    send_lat("sub_zero_lat", T_SUB, 8'h05, 8'h05);
    send_lat("sub_borrow_lat", T_SUB, 8'h00, 8'h01);

    // Shifts.
    send_lat("sra_lat", T_SRA, 8'h90, 8'h03);
    send_lat("srl_lat", T_SRL, 8'h90, 8'h04);
    send_lat("sll_lat", T_SLL, 8'h81, 8'h01);
    send_lat("srl0_lat", T_SRL, 8'h55, 8'h00);

    // Back-pressure: AND result held for 3 cycles while an XOR waits.
    send(T_AND, 8'hF0, 8'h3C);
    i_ready = 1'b0;
    i_opcode = T_XOR; i_operandA = 8'hA5; i_operandB = 8'h0F; i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clock);
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_ready", 32'(o_ready), 32'd0);
      check("bp_hold", 32'(outs()), 32'(model(T_AND, 8'hF0, 8'h3C)));
      @(posedge i_clock); #1;
    end
    i_ready = 1'b1;
    @(negedge i_clock);
    check("bp_take_ready", 32'(o_ready), 32'd1);
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    @(negedge i_clock);
    check("bp_xor_valid", 32'(o_valid), 32'd1);
    @(posedge i_clock); #1;

    // Four back-to-back ops with i_ready held high.
    for (int k = 0; k < 4; k++) begin
      i_opcode = b2b_op[k]; i_operandA = b2b_a[k]; i_operandB = b2b_b[k]; i_valid = 1'b1;
      @(negedge i_clock);
      check("b2b_ready", 32'(o_ready), 32'd1);
      if (k > 0) check("b2b_valid", 32'(o_valid), 32'd1);
      @(posedge i_clock); #1;
    end
    i_valid = 1'b0;
    @(negedge i_clock);
    check("b2b_valid_last", 32'(o_valid), 32'd1);
    @(posedge i_clock); #1;
    @(negedge i_clock);
    check("b2b_idle", 32'(o_valid), 32'd0);
    @(posedge i_clock); #1;

    // Undefined opcodes.
    send_lat("und_lat", T_UND, 8'hFF, 8'h00);
`ifndef ALU_SEQ_MUL_EN
    send_lat("mul_as_und_lat", T_MUL, 8'hFF, 8'h12);
`endif

`ifdef ALU_SEQ_MUL_EN
    // Multiply latency: valid exactly DW edges after accept.
    send(T_MUL, 8'hFD, 8'h03);
    for (int j = 0; j <= DW; j++) begin
      @(negedge i_clock);
      if (j == 0) check("mul_busy_ready", 32'(o_ready), 32'd0);
      if (j == DW - 1) check("mul_not_yet", 32'(o_valid), 32'd0);
      if (j == DW) check("mul_lat", 32'(o_valid), 32'd1);
    end
    @(posedge i_clock); #1;
    send(T_MUL, 8'h40, 8'h04);
    idle(DW + 2);

    // Reset three cycles into a multiply.
    send(T_MUL, 8'h12, 8'h34);
`else
    // Reset while a result is held under back-pressure.
    idle(2);
    i_ready = 1'b0;
    send(T_ADD, 8'h7F, 8'h01);
`endif
    repeat (2) @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    i_ready = 1'b1;
    sb_q.delete();
    @(negedge i_clock);
    check("mrst_valid", 32'(o_valid), 32'd0);
    check("mrst_outs", 32'(outs()), 32'd0);
    check("mrst_ready", 32'(o_ready), 32'd1);
    @(posedge i_clock); #1;
    send_lat("post_rst_add_lat", T_ADD, 8'h10, 8'h20);

    idle(3);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, handshaked successor to the team's combinational ALU, parametrised in `DATA_WIDTH`. It adds:

- variable shift amounts, plus SLL and NOR,
- a full-width zero flag,
- registered results with valid/ready flow control,
- an optional iterative multiplier.

It sits between operand fetch and writeback, and is the datapath block that the processor control FSM talks to.

## Interface
- `DATA_WIDTH`, default 8: operand and result width, must be ≥ 4. `SHAMT_W` = clog2(`DATA_WIDTH`) is a derived localparam.
- `i_clock`, input, 1: the only clock; all state updates on its rising edge.
- `i_reset`, input, 1: synchronous, active-high reset.
- `i_valid`, input, 1: an operation is presented.
- `o_ready`, output, 1: the block can accept an operation this cycle.
- `i_operandA`, input, `DATA_WIDTH`: signed operand A.
- `i_operandB`, input, `DATA_WIDTH`: signed operand B; bits [`SHAMT_W`-1:0] give the shift amount.
- `i_opcode`, input, 4: operation select.
- `o_valid`, output, 1: result and flags are valid.
- `i_ready`, input, 1: the consumer takes the result this cycle.
- `o_result`, output, `DATA_WIDTH`: signed result.
- `o_zero`, `o_carry`, `o_overflow`, `o_negative`, `o_exception`, output, 1 each: status flags.

## Operation
- **Accept:** an operation is accepted on a rising edge where `i_valid && o_ready`. Operands and opcode are latched at accept; later input changes have no effect.
- **States:**
  - IDLE: `o_ready`=1.
  - EXEC: multiply only; `o_ready`=0.
  - HOLD: `o_valid`=1; `o_ready`=`i_ready`.
- **Transitions:**
  - IDLE→HOLD on accept of a single-cycle op.
  - IDLE→EXEC on accept of MUL.
  - EXEC→HOLD when the iteration counter reaches 0.
  - In HOLD, if `i_ready`: →IDLE with no new accept, →HOLD (new result) on accept of a single-cycle op, →EXEC on accept of MUL.
- **Opcodes (unchanged encodings):**
  - ADD 1000: sum; carry = unsigned carry-out; overflow = signed overflow.
  - SUB 1010: A−B; carry = borrow, i.e. unsigned A<B; overflow = signed overflow.
  - AND 1100, OR 1101, XOR 1110, NOR 1111 (new).
  - SRA 0011, SRL 0010, SLL 0000 (new): shift by `B[SHAMT_W-1:0]`. Carry = last bit shifted out; for a shift amount of 0, the result is A and carry is 0.
- **Flags:**
  - `o_zero` = NOR over all `DATA_WIDTH` result bits.
  - `o_negative` = result MSB.
  - carry and overflow are 0 for any op not listed above.
- **Undefined opcode:** completes like a single-cycle op with result 0, `o_exception`=1 and all other flags 0. This is the only way `o_exception` is set.
- **HOLD stability:** result and all flags are registered and held stable while `o_valid && !i_ready`.

## Timing
- **Reset:** `i_reset` high at an edge sets state to IDLE and forces `o_result`=0, all flags 0 and `o_valid`=0. `o_ready`=1 once `i_reset` is low again.
- **Mid-operation reset:** an operation in EXEC or HOLD is discarded without output.
- **Single-cycle latency:** accept on edge N gives `o_valid`=1 after edge N.
- **Throughput:** one op per cycle while `i_ready`=1.
- **MUL latency:** accept on edge N gives `o_valid`=1 after edge N+`DATA_WIDTH`.
- **Back-pressure:** while in HOLD with `i_ready`=0, `o_ready`=0 and any `i_valid` is ignored.
- **Simultaneous consume and accept:** allowed in HOLD in the same cycle; no bubble for single-cycle ops.

## Configuration
- **`ALU_SEQ_MUL_EN` defined:**
  - opcode 0110 = MUL, computed by iterative shift-add, one bit per cycle, over `DATA_WIDTH` cycles in EXEC.
  - result = low `DATA_WIDTH` bits of the signed product.
  - overflow = 1 when the full signed product does not fit in `DATA_WIDTH` bits; carry = 0.
- **`ALU_SEQ_MUL_EN` undefined:**
  - no EXEC state and no multiplier logic.
  - 0110 is an undefined opcode (exception).

## Test plan
All scenarios use `DATA_WIDTH`=8.

1. ADD 0x7F+0x01 → 0x80 with overflow=1, negative=1, carry=0, zero=0, and `o_valid` one cycle after accept. Then SUB 0x05−0x05 → 0x00 with zero=1, carry=0; SUB 0x00−0x01 → 0xFF with carry=1, negative=1, overflow=0.
2. Shifts:
   - SRA A=0x90, B=3 → 0xF2, carry=0.
   - SRL A=0x90, B=4 → 0x09, carry=0.
   - SLL A=0x81, B=1 → 0x02, carry=1.
   - SRL A=0x55, B=0 → 0x55, carry=0.
3. Back-pressure:
   - `i_ready`=0 for 3 cycles after an AND result: result and flags are held, `o_ready`=0, and a presented XOR is not taken.
   - Raising `i_ready` with the XOR still presented: XOR accepted that cycle, its result valid next cycle.
   - 4 back-to-back ops with `i_ready`=1: 4 consecutive `o_valid` cycles.
4. Opcode 0111 with A=0xFF → result 0x00, exception=1, all other flags 0. Without `ALU_SEQ_MUL_EN`, opcode 0110 behaves identically.
5. With `ALU_SEQ_MUL_EN`:
   - 0xFD×0x03 → 0xF7, overflow=0, negative=1, `o_valid` 8 cycles after accept.
   - 0x40×0x04 → 0x00, overflow=1, zero=1.
6. Reset:
   - `i_reset` pulsed 3 cycles into a MUL → `o_valid`=0 and all outputs 0 after that edge, `o_ready`=1 the following cycle.
   - The next ADD completes normally.
